// File: rtl/present_pkg.sv
// present_pkg: S-box, P-layer helpers, FSM state encoding and round-counter width
// shared by the PRESENT cipher core and its key schedule.
package present_pkg;

    localparam int ROUND_BITS = 5;

    // Nibble i of each table lives at bits [4i+3:4i].
    localparam logic [63:0] SBOX_T     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] SBOX_INV_T = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_ENC    = 3'd2,
        ST_DEC    = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_T[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV_T[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] slayer(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [63:0] slayer_inv(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox_inv(s[4*i +: 4]);
        return o;
    endfunction

    // Bit i moves to bit 16*i mod 63; bit 63 stays put (carried by o = s).
    function automatic logic [63:0] player(input logic [63:0] s);
        logic [63:0] o;
        o = s;
        for (int i = 0; i < 63; i++) o[(16*i) % 63] = s[i];
        return o;
    endfunction

    function automatic logic [63:0] player_inv(input logic [63:0] s);
        logic [63:0] o;
        o = s;
        for (int i = 0; i < 63; i++) o[i] = s[(16*i) % 63];
        return o;
    endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// present_cipher_core_if: request/response handshake bundle between a host
// (master) and the PRESENT core (slave).
interface present_cipher_core_if #(parameter int KEY_BITS = 80);
    logic                in_valid;
    logic                in_ready;
    logic                in_dec;
    logic [63:0]         in_data;
    logic [KEY_BITS-1:0] in_key;
    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_data;

    modport master (
        output in_valid, in_dec, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_dec, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/present_key_sched.sv
// present_key_sched: combinational PRESENT key update; dir=0 gives upd(key, r),
// dir=1 gives inv_upd(key, r), for 80- or 128-bit keys.
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_BITS = 80
) (
    input  logic [KEY_BITS-1:0]   key,
    input  logic [ROUND_BITS-1:0] r,
    input  logic                  dir,
    output logic [KEY_BITS-1:0]   nxt
);
    localparam int LO = (KEY_BITS == 128) ? 62 : 15;
    localparam int NS = (KEY_BITS == 128) ? 2 : 1;

    logic [KEY_BITS-1:0] rot;
    logic [KEY_BITS-1:0] fwd;
    logic [KEY_BITS-1:0] x;

    // Counter field and S-boxed top nibbles never overlap, so order within a step is free.
    always_comb begin
        rot = {key[KEY_BITS-62:0], key[KEY_BITS-1:KEY_BITS-61]};
        fwd = rot;
        x = key;
        x[LO +: ROUND_BITS] = key[LO +: ROUND_BITS] ^ r;
        for (int i = 0; i < NS; i++) begin
            fwd[KEY_BITS-1-4*i -: 4] = sbox(rot[KEY_BITS-1-4*i -: 4]);
            x[KEY_BITS-1-4*i -: 4] = sbox_inv(x[KEY_BITS-1-4*i -: 4]);
        end
        fwd[LO +: ROUND_BITS] = rot[LO +: ROUND_BITS] ^ r;
        nxt = dir ? {x[60:0], x[KEY_BITS-1:61]} : fwd;
    end
endmodule

// File: rtl/present_cipher_core.sv
// present_cipher_core: iterative PRESENT encrypt/decrypt, one round per clock,
// 80/128-bit keys, valid/ready on both sides.
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_BITS = 80,
    parameter int ROUNDS   = 31
) (
    input logic clk,
    input logic rst,
    present_cipher_core_if.slave bus
);
    if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key
        $error("present_cipher_core: KEY_BITS must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_cipher_core: ROUNDS must be in 1..31");
    end

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] KEYEXP = ST_KEYEXP;
    localparam logic [2:0] ENC    = ST_ENC;
    localparam logic [2:0] DEC    = ST_DEC;
    localparam logic [2:0] HOLD   = ST_HOLD;
    localparam logic [ROUND_BITS-1:0] RMAX = ROUND_BITS'(ROUNDS);

    logic [2:0]            state;
    logic [63:0]           data;
    logic [KEY_BITS-1:0]   key;
    logic [KEY_BITS-1:0]   key_nxt;
    logic [ROUND_BITS-1:0] r;
    logic                  fin;
    logic [63:0]           out_q;
    logic [63:0]           rk;

    assign rk            = key[KEY_BITS-1 -: 64];
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = out_q;

    present_key_sched #(.KEY_BITS(KEY_BITS)) u_ks (
        .key (key),
        .r   (r),
        .dir (state == DEC),
        .nxt (key_nxt)
    );

    // fin marks that the last round is done; the following cycle applies the whitening key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            key   <= '0;
            r     <= '0;
            fin   <= 1'b0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    data  <= bus.in_data;
                    key   <= bus.in_key;
                    r     <= ROUND_BITS'(1);
                    fin   <= 1'b0;
                    state <= bus.in_dec ? KEYEXP : ENC;
                end
                KEYEXP: begin
                    key <= key_nxt;
                    if (r == RMAX) state <= DEC;
                    else r <= r + ROUND_BITS'(1);
                end
                ENC: if (fin) begin
                    out_q <= data ^ rk;
                    fin   <= 1'b0;
                    state <= HOLD;
                end else begin
                    data <= player(slayer(data ^ rk));
                    key  <= key_nxt;
                    if (r == RMAX) fin <= 1'b1;
                    else r <= r + ROUND_BITS'(1);
                end
                DEC: if (fin) begin
                    out_q <= data ^ rk;
                    fin   <= 1'b0;
                    state <= HOLD;
                end else begin
                    data <= slayer_inv(player_inv(data ^ rk));
                    key  <= key_nxt;
                    if (r == ROUND_BITS'(1)) fin <= 1'b1;
                    else r <= r - ROUND_BITS'(1);
                end
                HOLD: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_present_cipher_core.sv
// tb_present_cipher_core: directed vector table on 80- and 128-bit instances plus
// backpressure, late input changes and reset-abort sequences.
module tb_present_cipher_core;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_dec = 1'b0;
    logic         out_ready = 1'b0;
    logic [63:0]  in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    int           pass_cnt = 0;
    int           total = 0;

    always #5 clk = ~clk;

    present_cipher_core_if #(.KEY_BITS(80))  b80 ();
    present_cipher_core_if #(.KEY_BITS(128)) b128 ();

    assign b80.in_valid   = in_valid & ~sel;
    assign b80.in_dec     = in_dec;
    assign b80.in_data    = in_data;
    assign b80.in_key     = in_key[79:0];
    assign b80.out_ready  = out_ready & ~sel;
    assign b128.in_valid  = in_valid & sel;
    assign b128.in_dec    = in_dec;
    assign b128.in_data   = in_data;
    assign b128.in_key    = in_key;
    assign b128.out_ready = out_ready & sel;
    assign in_ready  = sel ? b128.in_ready  : b80.in_ready;
    assign out_valid = sel ? b128.out_valid : b80.out_valid;
    assign out_data  = sel ? b128.out_data  : b80.out_data;

    present_cipher_core #(.KEY_BITS(80), .ROUNDS(31)) u80 (
        .clk (clk),
        .rst (rst),
        .bus (b80)
    );
    present_cipher_core #(.KEY_BITS(128), .ROUNDS(31)) u128 (
        .clk (clk),
        .rst (rst),
        .bus (b128)
    );

    typedef struct {
        bit           k128;
        bit           dec;
        logic [63:0]  din;
        logic [127:0] key;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Called at a negedge; returns just after the acceptance edge.
    task automatic accept();
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        @(negedge clk);
        sel = v.k128;
        in_dec = v.dec;
        in_data = v.din;
        in_key = v.key;
        accept();
        wait_out(n);
        chk({name, "_lat"}, 64'(n), v.dec ? 64'd63 : 64'd32);
        chk({name, "_data"}, out_data, v.exp);
        handshake();
    endtask

    localparam logic [127:0] KF80 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF;

    initial begin
        int n;
        int cnt;
        vecs[0] = '{1'b0, 1'b0, 64'h0,                  128'h0, 64'h5579c1387b228445};
        vecs[1] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, KF80,   64'h3333dcd3213210d2};
        vecs[2] = '{1'b0, 1'b0, 64'h0,                  KF80,   64'he72c46c0f5945049};
        vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0, 64'ha112ffc72f68417b};
        vecs[4] = '{1'b0, 1'b1, 64'he72c46c0f5945049,    KF80,   64'h0};
        vecs[5] = '{1'b0, 1'b1, 64'h5579c1387b228445,    128'h0, 64'h0};
        vecs[6] = '{1'b0, 1'b1, 64'h3333dcd3213210d2,    KF80,   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{1'b0, 1'b1, 64'ha112ffc72f68417b,    128'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8] = '{1'b1, 1'b0, 64'h0,                  128'h0, 64'h96db702a2e6900af};
        vecs[9] = '{1'b1, 1'b1, 64'h96db702a2e6900af,    128'h0, 64'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held for 10 cycles while a new request waits.
        @(negedge clk);
        sel = 1'b0;
        in_dec = 1'b0;
        in_data = 64'h0;
        in_key = 128'h0;
        accept();
        wait_out(n);
        chk("bp_lat", 64'(n), 64'd32);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        in_key = KF80;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", out_data, 64'h5579c1387b228445);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        // Mode and key changes after acceptance must not affect the block.
        #1 in_valid = 1'b0;
        in_dec = 1'b1;
        in_key = 128'h0;
        wait_out(n);
        chk("b2b_lat", 64'(n), 64'd32);
        chk("b2b_data", out_data, 64'h3333dcd3213210d2);
        handshake();

        // Reset abort in the middle of a decrypt.
        in_dec = 1'b1;
        in_data = 64'he72c46c0f5945049;
        in_key = KF80;
        accept();
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_valid", 64'(cnt), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_data", out_data, 64'h0);
        run_vec(vecs[0], "post_abort");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
